// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Conditions N independent board inputs (buttons, switches, keyboard enter
//   strobe) for the datapath. Each channel goes through a synchroniser, an
//   optional polarity inversion and a counter-based debouncer. The debounced
//   level produces registered rise/fall pulses and a sticky rise flag that
//   the datapath clears with a write-1-to-clear strobe.
//
// Ports:
//   clk           board clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   raw_in        unsynchronised pin levels
//   level_out     debounced, polarity-corrected level (1 = asserted)
//   rise_pulse    one-cycle pulse when level_out goes 0->1
//   fall_pulse    one-cycle pulse when level_out goes 1->0
//   event_sticky  latched rise events, held until cleared
//   clr_event     write-1-to-clear strobe for event_sticky bits
//   any_event     registered OR of event_sticky (one cycle behind)
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int                  CHANNELS      = 8,
  parameter int                  STABLE_CYCLES = 1000000,
  parameter int                  SYNC_STAGES   = 2,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] event_sticky,
  input  logic [CHANNELS-1:0] clr_event,
  output logic                any_event
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] r_sticky;
  logic                r_any;

  logic [CHANNELS-1:0] w_sync_val;
  logic [CHANNELS-1:0] w_flip;

  // Inverted channels reset their chain to 1 so the corrected value is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= INVERT_MASK;
      end
    end else begin
      r_sync[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync_val = r_sync[SYNC_STAGES-1] ^ INVERT_MASK;

  // Per-channel debounce counter: counts consecutive cycles where the
  // synchronised value disagrees with the debounced level. It clears on the
  // flip itself, so a long hold can never wrap and re-trigger.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             w_diff;

      assign w_diff     = w_sync_val[gi] ^ r_level[gi];
      assign w_flip[gi] = w_diff && (r_cnt == CNT_MAX);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (!w_diff || w_flip[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Pulses are registered alongside the level so they line up with the
  // cycle in which level_out shows its new value. A sticky set (rise) takes
  // priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_sticky <= '0;
      r_any    <= 1'b0;
    end else begin
      r_level  <= r_level ^ w_flip;
      r_rise   <= w_flip & ~r_level;
      r_fall   <= w_flip & r_level;
      r_sticky <= (r_sticky & ~clr_event) | r_rise;
      r_any    <= |r_sticky;
    end
  end

  assign level_out    = r_level;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign event_sticky = r_sticky;
  assign any_event    = r_any;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised N-channel conditioner for board inputs: reset/finish buttons, switches, keyboard "enter" strobe.
- Replaces per-signal debounce instances at top level, and the ad-hoc OR of finish with keyboard enter.
- Per channel: synchroniser, programmable-polarity inversion, counter-based debounce, rise/fall edge pulses, sticky event flag that the datapath clears by write-1-to-clear.
- Sits between board pins and the datapath I/O map; runs on the 100 MHz board clock.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).
- STABLE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the debounced level before the level flips (10 ms at 100 MHz); legal range >= 2.
- SYNC_STAGES, 2, flip-flop stages in each synchroniser chain (2..4).
- INVERT_MASK, {CHANNELS{1'b0}}, bit i = 1: channel i is active-low at the pin and is inverted after synchronisation.

Ports:
- clk  in  1  board clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raw_in  in  CHANNELS  unsynchronised pin levels.
- level_out  out  CHANNELS  debounced, polarity-corrected level (1 = asserted).
- rise_pulse  out  CHANNELS  one-cycle pulse when level_out goes 0->1.
- fall_pulse  out  CHANNELS  one-cycle pulse when level_out goes 1->0.
- event_sticky  out  CHANNELS  latched rise events, held until cleared.
- clr_event  in  CHANNELS  write-1-to-clear strobe for event_sticky bits.
- any_event  out  1  OR-reduction of event_sticky.

Behaviour:
- Reset (async assert, sync deassert by the top-level reset synchroniser):
  - All synchroniser stages cleared, so post-inversion value is 0 for channels not in INVERT_MASK.
  - For inverted channels the sync chain resets to 1, so the post-inversion value is 0.
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, event_sticky = 0, any_event = 0.
  - All counters = 0.
- Synchroniser: SYNC_STAGES flops per bit. s_i = last stage XOR INVERT_MASK[i].
- Debounce, per channel, counter width $clog2(STABLE_CYCLES):
  - s_i == level_out[i]: counter <= 0.
  - s_i != level_out[i] and counter < STABLE_CYCLES-1: counter increments.
  - s_i != level_out[i] and counter == STABLE_CYCLES-1: level_out[i] toggles and counter <= 0.
  - Any single cycle where s_i matches level_out restarts the count. Glitches shorter than STABLE_CYCLES cycles never reach level_out.
- Latency: a clean pin transition reaches level_out exactly SYNC_STAGES + STABLE_CYCLES cycles later.
- Edge pulses:
  - Registered; asserted in the same cycle level_out shows its new value, for exactly one cycle.
  - Rise and fall on one channel are never asserted together.
- Sticky flags:
  - event_sticky[i] sets in the cycle rise_pulse[i] is high.
  - clr_event[i] = 1 clears it on the next edge.
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Clearing an already-clear bit has no effect.
  - clr_event has no effect on level_out or on the counters.
- any_event: registered, follows event_sticky with one cycle of delay. It is the datapath "finish" source; keyboard enter is wired to a spare channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count: counter and level are discarded immediately. After release a held input must complete a full STABLE_CYCLES window before level_out asserts.
- A held input never produces more than one rise_pulse, regardless of duration. There is no counter wrap, because the counter saturates by clearing on toggle.

Test Plan (CHANNELS=4, STABLE_CYCLES=8, SYNC_STAGES=2, INVERT_MASK=4'b0010):
- Reset with raw_in=4'b0010 -> all outputs 0 throughout reset and for 20 cycles after release; the inverted channel 1 reads idle.
- raw_in[0] 0->1 held -> level_out[0]=1 exactly 10 cycles later; rise_pulse[0] high for that one cycle only; event_sticky[0]=1 from the next cycle; any_event=1 one cycle after that.
- raw_in[2] pulses high for 7 cycles then low -> level_out[2], rise_pulse[2] and event_sticky[2] stay 0. The same pulse at 8 cycles -> level_out[2] rises.
- Bounce on raw_in[3] (1,0,1,1,0,1 over 6 cycles, then held 1) -> exactly one rise_pulse[3], 10 cycles after the last 0->1.
- event_sticky[0]=1; drive clr_event[0] in the same cycle as a new rise_pulse[0] -> bit remains 1. Drive clr_event[0] alone -> bit 0 and any_event return to 0 on the following cycles.
- Hold raw_in[1]=0 (asserted, active-low) and drop rst_n after 5 cycles of counting -> level_out[1]=0 immediately. After release, level_out[1]=1 only after a full 10-cycle window.
